// File: rtl/alu_if.sv
// Execute-stage ALU bus: operands and op select in, combinational result plus
// registered result and status flags out.
interface alu_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       alu_op;
   logic             in_valid;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_q;
   logic             valid_q;
   logic             zero_q;
   logic             neg_q;
   logic             ovf_q;

   modport master (
      output a, b, alu_op, in_valid,
      input  result, result_q, valid_q, zero_q, neg_q, ovf_q
   );

   modport slave (
      input  a, b, alu_op, in_valid,
      output result, result_q, valid_q, zero_q, neg_q, ovf_q
   );
endinterface

// File: rtl/alu.sv
// RV32I integer ALU: zero-latency combinational result for single-cycle use and
// a one-cycle registered copy with zero/negative/overflow flags for pipelines.
module alu #(
   parameter int WIDTH = 32
) (
   input logic   clk,
   input logic   rst,
   alu_if.slave  bus
);

   localparam int SW  = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b0001;
   localparam logic [3:0] OP_SLT  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SRA  = 4'b1101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [SW-1:0]    shamt;
   logic [WIDTH-1:0] res;
   logic             ovf;
   logic             lts;
   logic             ltu;

   // Shared adder/subtractor and compare terms feeding the result mux
   assign sum   = bus.a + bus.b;
   assign diff  = bus.a - bus.b;
   assign shamt = bus.b[SW-1:0];
   assign lts   = $signed(bus.a) < $signed(bus.b);
   assign ltu   = bus.a < bus.b;

   // Result mux; unused op codes yield zero with no overflow
   always_comb begin
      res = '0;
      ovf = 1'b0;
      case (bus.alu_op)
         OP_ADD: begin
            res = sum;
            ovf = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
         end
         OP_SUB: begin
            res = diff;
            ovf = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
         end
         OP_SLL:  res = bus.a << shamt;
         OP_SLT:  res = {{(WIDTH-1){1'b0}}, lts};
         OP_SLTU: res = {{(WIDTH-1){1'b0}}, ltu};
         OP_XOR:  res = bus.a ^ bus.b;
         OP_SRL:  res = bus.a >> shamt;
         OP_SRA:  res = $unsigned($signed(bus.a) >>> shamt);
         OP_OR:   res = bus.a | bus.b;
         OP_AND:  res = bus.a & bus.b;
         default: begin
            res = '0;
            ovf = 1'b0;
         end
      endcase
   end

   assign bus.result = res;

   // Registered copy; reset state reports zero so zero_q agrees with result_q
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.result_q <= '0;
         bus.valid_q  <= 1'b0;
         bus.zero_q   <= 1'b1;
         bus.neg_q    <= 1'b0;
         bus.ovf_q    <= 1'b0;
      end else begin
         bus.valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            bus.result_q <= res;
            bus.zero_q   <= (res == '0);
            bus.neg_q    <= res[MSB];
            bus.ovf_q    <= ovf;
         end
      end
   end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: arithmetic reference model with a per-cycle
// comparator, plus directed vectors carrying hand-computed results.
module tb_alu;

   localparam longint MAXS = 64'sd2147483647;
   localparam longint MINS = -64'sd2147483648;

   logic clk = 1'b0;
   logic rst;
   logic checking = 1'b0;
   int   nvec = 0;
   int   nfail = 0;

   logic [31:0] mq;
   logic        mv;
   logic        mz;
   logic        mn;
   logic        mo;

   alu_if #(.WIDTH(32)) bus ();

   alu #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference result from plain integer arithmetic on widened operands
   function automatic logic [31:0] mres(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub, p, t;
      int     sh;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      sh = int'(b % 32);
      p  = 64'sd1 << sh;
      t  = 64'sd0;
      case (op)
         4'b0000: t = ua + ub;
         4'b1000: t = ua - ub;
         4'b0001: t = ua * p;
         4'b0010: t = (sa < sb) ? 64'sd1 : 64'sd0;
         4'b0011: t = (ua < ub) ? 64'sd1 : 64'sd0;
         4'b0100: t = ua ^ ub;
         4'b0101: t = ua / p;
         4'b1101: t = (sa >= 0) ? sa / p : (sa - p + 64'sd1) / p;
         4'b0110: t = ua | ub;
         4'b0111: t = ua & ub;
         default: t = 64'sd0;
      endcase
      return t[31:0];
   endfunction

   // Overflow means the exact signed answer does not fit in 32 bits
   function automatic logic movf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, s;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (op == 4'b0000)      s = sa + sb;
      else if (op == 4'b1000) s = sa - sb;
      else                    s = 64'sd0;
      return (s > MAXS) || (s < MINS);
   endfunction

   // Expected registered state, updated from the model at every edge
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq <= 32'h0;
         mv <= 1'b0;
         mz <= 1'b1;
         mn <= 1'b0;
         mo <= 1'b0;
      end else begin
         mv <= bus.in_valid;
         if (bus.in_valid) begin
            mq <= mres(bus.alu_op, bus.a, bus.b);
            mz <= (mres(bus.alu_op, bus.a, bus.b) == 32'h0);
            mn <= mres(bus.alu_op, bus.a, bus.b) >= 32'h80000000;
            mo <= movf(bus.alu_op, bus.a, bus.b);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nfail++;
         $display("[TB] FAIL %s: got %08h, expected %08h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic valid);
      bus.alu_op   = op;
      bus.a        = a;
      bus.b        = b;
      bus.in_valid = valid;
   endtask

   // Directed vector: literal combinational result, then literal registered flags
   task automatic runVector(input string name, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input logic expOvf);
      applyStimulus(op, a, b, 1'b1);
      #1;
      checkOutput({name, "_comb"}, bus.result, exp);
      @(posedge clk);
      #1;
      checkOutput({name, "_result_q"}, bus.result_q, exp);
      checkOutput({name, "_ovf_q"}, 32'(bus.ovf_q), 32'(expOvf));
      checkOutput({name, "_neg_q"}, 32'(bus.neg_q), 32'(exp[31]));
   endtask

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (checking) begin
         checkOutput("model_result", bus.result, mres(bus.alu_op, bus.a, bus.b));
         checkOutput("model_result_q", bus.result_q, mq);
         checkOutput("model_valid_q", 32'(bus.valid_q), 32'(mv));
         checkOutput("model_zero_q", 32'(bus.zero_q), 32'(mz));
         checkOutput("model_neg_q", 32'(bus.neg_q), 32'(mn));
         checkOutput("model_ovf_q", 32'(bus.ovf_q), 32'(mo));
      end
   end

   initial begin
      rst = 1'b1;
      applyStimulus(4'b0000, 32'h0, 32'h0, 1'b0);
      #12;
      checkOutput("rst_result_q", bus.result_q, 32'h0);
      checkOutput("rst_valid_q", 32'(bus.valid_q), 32'h0);
      checkOutput("rst_zero_q", 32'(bus.zero_q), 32'h1);
      checkOutput("rst_neg_q", 32'(bus.neg_q), 32'h0);
      checkOutput("rst_ovf_q", 32'(bus.ovf_q), 32'h0);
      rst = 1'b0;
      checking = 1'b1;

      runVector("add_ovf",   4'b0000, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b1);
      runVector("add_neg",   4'b0000, 32'h80000000, 32'h00000001, 32'h80000001, 1'b0);
      runVector("sub_0m1",   4'b1000, 32'h00000000, 32'h00000001, 32'hffffffff, 1'b0);
      runVector("sub_m1m1",  4'b1000, 32'hffffffff, 32'h00000001, 32'hfffffffe, 1'b0);
      runVector("sub_ovf",   4'b1000, 32'h80000000, 32'h00000001, 32'h7fffffff, 1'b1);
      runVector("or",        4'b0110, 32'hf0a75c7a, 32'hf518a300, 32'hf5bfff7a, 1'b0);
      runVector("and",       4'b0111, 32'h8080ff00, 32'hff00faff, 32'h8000fa00, 1'b0);
      runVector("xor",       4'b0100, 32'hf0a73c7a, 32'hf518330f, 32'h05bf0f75, 1'b0);
      runVector("slt_neg",   4'b0010, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0);
      runVector("sltu_big",  4'b0011, 32'h80000000, 32'h00000001, 32'h00000000, 1'b0);
      runVector("slt_12",    4'b0010, 32'h00000001, 32'h00000002, 32'h00000001, 1'b0);
      runVector("sltu_12",   4'b0011, 32'h00000001, 32'h00000002, 32'h00000001, 1'b0);
      runVector("sll_4",     4'b0001, 32'hffffff00, 32'h00000004, 32'hfffff000, 1'b0);
      runVector("sll_24",    4'b0001, 32'hffffff00, 32'h00000024, 32'hfffff000, 1'b0);
      runVector("srl_4",     4'b0101, 32'hffffff00, 32'h00000004, 32'h0ffffff0, 1'b0);
      runVector("srl_24",    4'b0101, 32'hffffff00, 32'h00000024, 32'h0ffffff0, 1'b0);
      runVector("sra_4",     4'b1101, 32'hffffff00, 32'h00000004, 32'hfffffff0, 1'b0);
      runVector("sra_pos8",  4'b1101, 32'h7fffff00, 32'h00000008, 32'h007fffff, 1'b0);
      runVector("sra_pos28", 4'b1101, 32'h7fffff00, 32'h00000028, 32'h007fffff, 1'b0);
      runVector("sll_0",     4'b0001, 32'h12345678, 32'h00000000, 32'h12345678, 1'b0);
      runVector("srl_20",    4'b0101, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0);
      runVector("bad_op",    4'b1001, 32'h7fffffff, 32'h00000001, 32'h00000000, 1'b0);

      runVector("sub_zero",  4'b1000, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0);
      checkOutput("sub_zero_zero_q", 32'(bus.zero_q), 32'h1);
      checkOutput("sub_zero_valid_q", 32'(bus.valid_q), 32'h1);

      applyStimulus(4'b0000, 32'h00000003, 32'h00000004, 1'b0);
      #1;
      checkOutput("hold_comb", bus.result, 32'h00000007);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("hold_result_q", bus.result_q, 32'h00000000);
      checkOutput("hold_zero_q", 32'(bus.zero_q), 32'h1);
      checkOutput("hold_valid_q", 32'(bus.valid_q), 32'h0);

      runVector("pre_rst", 4'b0000, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midrst_result_q", bus.result_q, 32'h0);
      checkOutput("midrst_valid_q", 32'(bus.valid_q), 32'h0);
      checkOutput("midrst_zero_q", 32'(bus.zero_q), 32'h1);
      checkOutput("midrst_neg_q", 32'(bus.neg_q), 32'h0);
      checkOutput("midrst_ovf_q", 32'(bus.ovf_q), 32'h0);
      checkOutput("midrst_comb", bus.result, 32'h80000000);
      #4;
      rst = 1'b0;

      for (int op = 0; op < 16; op++) begin
         applyStimulus(4'(op), 32'h89abcdef, 32'h00000013, 1'b1);
         @(posedge clk);
         #1;
         applyStimulus(4'(op), 32'h7fffffff, 32'hffffffff, 1'b1);
         @(posedge clk);
         #1;
      end

      @(negedge clk);
      #1;
      checking = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
